// File: rtl/cbfp0_denorm_if.sv
// Lane bus for the CBFP0 de-normaliser: input samples/indices and output samples/framing.
interface cbfp0_denorm_if #(
    parameter int unsigned IN_W  = 11,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned NCHAN = 16,
    parameter int unsigned IDX_W = 5
) ();

    // Input side: block-floating-point lanes with per-lane shift index
    logic                              valid_in;
    logic [NCHAN-1:0][IN_W-1:0]        data_re_in;
    logic [NCHAN-1:0][IN_W-1:0]        data_im_in;
    logic [NCHAN-1:0][IDX_W-1:0]       idx_in;

    // Output side: common-scale lanes plus burst framing
    logic                              valid_out;
    logic [NCHAN-1:0][OUT_W-1:0]       data_re_out;
    logic [NCHAN-1:0][OUT_W-1:0]       data_im_out;
    logic                              frame_start_out;
    logic                              frame_end_out;
    logic                              burst_err;

    // Producer of input lanes / consumer of results
    modport master (
        output valid_in, data_re_in, data_im_in, idx_in,
        input  valid_out, data_re_out, data_im_out,
        input  frame_start_out, frame_end_out, burst_err
    );

    // The de-normaliser itself
    modport slave (
        input  valid_in, data_re_in, data_im_in, idx_in,
        output valid_out, data_re_out, data_im_out,
        output frame_start_out, frame_end_out, burst_err
    );

endinterface

// File: rtl/cbfp0_denorm.sv
// CBFP0 de-normaliser: per-lane arithmetic right shift by the block index with
// round-half-up and saturation, 2-stage pipeline, 32-beat burst framing tracker.
module cbfp0_denorm #(
    parameter int unsigned IN_W      = 11,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned NCHAN     = 16,
    parameter int unsigned IDX_W     = 5,
    parameter int unsigned BIAS      = 5,
    parameter int unsigned MAX_SHIFT = 20,
    parameter int unsigned BURST_LEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    cbfp0_denorm_if.slave bus
);

    // Working width: must hold the pre-shifted sample and the largest rounding
    // constant 2^(MAX_SHIFT-1) with a spare bit so the add never overflows.
    localparam int unsigned SW = IN_W + BIAS + 1;
    localparam int unsigned RW = MAX_SHIFT + 2;
    localparam int unsigned AW = (SW > RW) ? SW : RW;
    localparam int unsigned CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [CW-1:0]          LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0]       K_MAX     = IDX_W'(MAX_SHIFT);
    localparam logic signed [AW-1:0]   SAT_MAX   = AW'((longint'(1) <<< (OUT_W - 1)) - longint'(1));
    localparam logic signed [AW-1:0]   SAT_MIN   = AW'(-(longint'(1) <<< (OUT_W - 1)));

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // De-normalise one sample: clamp index, pre-shift, round half up, saturate
    function automatic logic [OUT_W-1:0] denorm(
        input logic [IN_W-1:0]  x,
        input logic [IDX_W-1:0] idx
    );
        logic [IDX_W-1:0]      k;
        logic signed [AW-1:0]  s;
        logic signed [AW-1:0]  rnd;
        logic signed [AW-1:0]  r;
        logic [OUT_W-1:0]      y;
        k   = (idx > K_MAX) ? K_MAX : idx;
        s   = AW'($signed(x)) <<< BIAS;
        rnd = '0;
        if (k == '0) begin
            r = s;
        end else begin
            rnd = AW'(1) <<< (k - IDX_W'(1));
            r   = (s + rnd) >>> k;
        end
        if (r > SAT_MAX) begin
            y = SAT_MAX[OUT_W-1:0];
        end else if (r < SAT_MIN) begin
            y = SAT_MIN[OUT_W-1:0];
        end else begin
            y = r[OUT_W-1:0];
        end
        return y;
    endfunction

    // ------------------------------------------------------------------
    // Burst tracker (input side)
    // ------------------------------------------------------------------
    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic            tag_start_c;
    logic            tag_end_c;
    logic            err_set_c;

    // Burst state and beat counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next burst state, beat tags and broken-burst detection
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        tag_start_c = 1'b0;
        tag_end_c   = 1'b0;
        err_set_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    tag_start_c = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        // single-beat bursts start and end on the same beat
                        tag_end_c = 1'b1;
                        cnt_nx    = '0;
                    end else begin
                        cnt_nx   = cnt + CW'(1);
                        state_nx = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (bus.valid_in) begin
                    if (cnt == LAST_BEAT) begin
                        tag_end_c = 1'b1;
                        cnt_nx    = '0;
                        state_nx  = ST_IDLE;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end else begin
                    // gap inside a burst: flag it and restart framing
                    err_set_c = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 1: capture lanes, indices, valid and framing tags
    // ------------------------------------------------------------------
    logic                          s1_valid;
    logic                          s1_start;
    logic                          s1_end;
    logic [NCHAN-1:0][IN_W-1:0]    s1_re;
    logic [NCHAN-1:0][IN_W-1:0]    s1_im;
    logic [NCHAN-1:0][IDX_W-1:0]   s1_idx;

    // Input register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_start <= 1'b0;
            s1_end   <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= bus.valid_in;
            s1_start <= bus.valid_in & tag_start_c;
            s1_end   <= bus.valid_in & tag_end_c;
            s1_re    <= bus.data_re_in;
            s1_im    <= bus.data_im_in;
            s1_idx   <= bus.idx_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: shift, round, saturate and register outputs
    // ------------------------------------------------------------------
    logic [NCHAN-1:0][OUT_W-1:0]   re_c;
    logic [NCHAN-1:0][OUT_W-1:0]   im_c;

    // Per-lane de-normalisation; idle beats produce zero
    always_comb begin
        re_c = '0;
        im_c = '0;
        if (s1_valid) begin
            for (int unsigned l = 0; l < NCHAN; l++) begin
                re_c[l] = denorm(s1_re[l], s1_idx[l]);
                im_c[l] = denorm(s1_im[l], s1_idx[l]);
            end
        end
    end

    // Output register stage and sticky burst error
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_out       <= 1'b0;
            bus.frame_start_out <= 1'b0;
            bus.frame_end_out   <= 1'b0;
            bus.data_re_out     <= '0;
            bus.data_im_out     <= '0;
            bus.burst_err       <= 1'b0;
        end else begin
            bus.valid_out       <= s1_valid;
            bus.frame_start_out <= s1_start;
            bus.frame_end_out   <= s1_end;
            bus.data_re_out     <= re_c;
            bus.data_im_out     <= im_c;
            bus.burst_err       <= bus.burst_err | err_set_c;
        end
    end

endmodule

// File: doc/cbfp0_denorm.md
Name: cbfp0_denorm

Overview:
- Inverse of the CBFP0 normalisation stage. Takes 16-lane block-floating-point samples (<5.6>) with their per-lane 5-bit shift indices and restores a common fixed-point scale.
- Applies an arithmetic right shift by each lane's index, with round-half-up and saturation.
- Sits downstream of the FFT pipeline, before output reordering. Also tracks 32-cycle bursts and flags broken bursts.

Parameters:
- IN_W, 11, input sample width, signed <5.6>
- OUT_W, 16, output sample width, signed
- NCHAN, 16, lanes per cycle
- IDX_W, 5, shift-index width
- BIAS, 5, left pre-shift applied before de-normalising
- MAX_SHIFT, 20, clamp for index values
- BURST_LEN, 32, valid cycles per block

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- valid_in  input  1  lane data and indices are valid this cycle
- data_re_in  input  IN_W x NCHAN  signed real parts
- data_im_in  input  IN_W x NCHAN  signed imaginary parts
- idx_in  input  IDX_W x NCHAN  per-lane shift index (the idx0 produced by CBFP0)
- data_re_out  output  OUT_W x NCHAN  de-normalised real parts
- data_im_out  output  OUT_W x NCHAN  de-normalised imaginary parts
- valid_out  output  1  output valid
- frame_start_out  output  1  pulses with the first output beat of a burst
- frame_end_out  output  1  pulses with the last output beat of a burst
- burst_err  output  1  sticky flag: valid_in dropped mid-burst

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, burst counter 0, both pipeline stages flushed.
- Reset mid-burst: takes effect at the next edge; in-flight beats are discarded and no valid_out follows.
- Pipeline: 2 stages, no backpressure. valid_out equals valid_in delayed by exactly 2 cycles.
  - S1 registers data, indices and valid.
  - S2 computes, saturates and registers the outputs.
- Idle outputs: data outputs are forced to 0 whenever valid_out = 0.
- Per lane, same rule for re and im:
  - k = min(idx, MAX_SHIFT).
  - s = sign_extend(in) <<< BIAS, with width IN_W+BIAS+1.
  - If k = 0: r = s.
  - Otherwise: r = (s + 2^(k-1)) >>> k. This is round half toward +inf. The intermediate is wide enough that the add cannot overflow.
  - Saturate r to signed OUT_W: values above the max become 2^(OUT_W-1)-1; values below the min become -2^(OUT_W-1).
- Burst counter (input side, 0..BURST_LEN-1):
  - Increments on each valid_in cycle and wraps to 0 after BURST_LEN-1.
  - The beat taken at count 0 is tagged start. The beat taken at count BURST_LEN-1 is tagged end.
  - Tags travel through the pipeline with the data, so frame_start_out and frame_end_out are 1-cycle pulses aligned with valid_out.
  - Back-to-back bursts with no idle gap are legal: an end pulse is followed directly by the next start pulse.
- Broken burst:
  - If valid_in = 0 while the counter is nonzero, burst_err is set and the counter returns to 0.
  - Beats already accepted still emerge normally, but no frame_end_out is produced for the broken burst.
  - The next valid_in beat starts a new burst.
  - burst_err is cleared only by rst.
- Out-of-range index: values above MAX_SHIFT are clamped silently; burst_err is not set.

Test Plan:
- Basic shift: re=100, im=-100, idx=2 on all lanes, one beat. Expect re=800, im=-800, valid_out exactly 2 cycles after valid_in.
- Rounding, with BIAS=5:
  - in=1, idx=6 -> 1; in=-1, idx=6 -> 0
  - in=3, idx=7 -> 1; in=-3, idx=7 -> -1
  - in=0, idx=0 -> 0; in=-1024, idx=0 -> -32768
- Clamp and saturation:
  - idx=31 with in=-1023 -> 0, treated as k=20.
  - Rebuild with OUT_W=12, BIAS=5: in=1023, idx=0 saturates to 2047; in=-1024, idx=0 -> -2048.
- Framing: two back-to-back 32-beat bursts with per-beat ramp data.
  - Expect frame_start_out at output beats 0 and 32, frame_end_out at beats 31 and 63.
  - Expect 64 valid_out cycles and burst_err=0.
- Broken burst: drop valid_in after beat 10, then send 32 beats.
  - Expect burst_err=1 from the cycle after the drop, 10 outputs with no end pulse, then a fresh start pulse and an end pulse on the 32nd beat.
- Reset: assert rst mid-burst at beat 5.
  - Expect valid_out, burst_err and all data 0 from the next edge, with no leftover output.
  - A subsequent burst frames from count 0.
